my_ram_8_ctrl: RTL
==================

// Module: my_ram_8_ctrl
// PURPOSE
//   Initiator-side controller for the 8-word x 16-bit RAM (my_ram_8-style responder).
//   - Accepts READ/WRITE/FILL commands on a valid/ready port.
//   - Drives the RAM's addr/in/load pins and samples its combinational out.
//   - Returns one response per command on a valid/ready response port.
//   - Sits between CPU/test logic and the RAM bank; sole owner of the RAM's load line.
// PARAMETERS
//   DATA_W  16  word width; must match RAM in/out
//   ADDR_W  3   address width; DEPTH = 2**ADDR_W (localparam, 8)
// PORTS
//   clk        in   1       rising-edge clock (shared with RAM)
//   reset      in   1       synchronous, active-high reset
//   cmd_valid  in   1       command offered
//   cmd_ready  out  1       controller idle, can accept
//   cmd_op     in   2       00 READ, 01 WRITE, 10 FILL, 11 reserved
//   cmd_addr   in   ADDR_W  target word (ignored by FILL)
//   cmd_data   in   DATA_W  write/fill value
//   rsp_valid  out  1       response available
//   rsp_ready  in   1       response consumed
//   rsp_data   out  DATA_W  READ: word read; WRITE/FILL: value written; reserved: 0
//   rsp_err    out  1       reserved op, or readback mismatch (see CONFIGURATION)
//   ram_addr   out  ADDR_W  to RAM addr
//   ram_in     out  DATA_W  to RAM in
//   ram_load   out  1       to RAM load; RAM captures ram_in on the edge where it is 1
//   ram_out    in   DATA_W  from RAM out; combinational in ram_addr
// BEHAVIOUR
//   - Reset: state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; ram_addr=0; ram_load=0.
//   - ram_load is gated by !reset, so no RAM write occurs in any reset cycle.
//   - FSM states: IDLE, READ, WRITE, FILL, VERIFY (macro only), RESP.
//   - IDLE: cmd_ready=1.
//       On cmd_valid & cmd_ready: latch op/addr/data into op_q/addr_q/data_q.
//       Next state: READ / WRITE / FILL; op 11 -> RESP with rsp_err=1, rsp_data=0.
//   - READ (1 cycle): ram_addr=addr_q, ram_load=0.
//       rsp_data<=ram_out at the edge; -> RESP.
//   - WRITE (1 cycle): ram_addr=addr_q, ram_in=data_q, ram_load=1.
//       rsp_data<=data_q; -> RESP (or VERIFY with macro).
//   - FILL: 3-bit counter cnt starts at 0.
//       Each cycle: ram_addr=cnt, ram_in=data_q, ram_load=1.
//       cnt==DEPTH-1 -> RESP, rsp_data<=data_q; exactly DEPTH load cycles.
//   - RESP: rsp_valid=1; rsp_data/rsp_err held stable until rsp_valid & rsp_ready.
//       On handshake -> IDLE; rsp_err cleared on leaving RESP.
//   - Outside IDLE: cmd_ready=0, and cmd_valid is ignored.
//   - Outside READ/WRITE/FILL/VERIFY: ram_load=0 and ram_addr=0.
//   - ram_in=data_q in all states.
//   - Latency, counted in edges after the accept edge until rsp_valid is high:
//       READ 2, WRITE 2 (3 with macro), FILL DEPTH+1 = 9, reserved 1.
//   - Throughput: one command in flight; next accept is no earlier than the cycle after the response handshake.
//   - Reset mid-operation: abort to IDLE at the reset edge.
//       Words already written stay written; no partial response is emitted.
//   - FILL cnt wraps 7->0 only via exit; no wrap-around writes.
// CONFIGURATION
//   MY_RAM_8_CTRL_READBACK_EN defined:
//     - WRITE -> VERIFY (1 cycle): ram_addr=addr_q, ram_load=0.
//     - rsp_err<=(ram_out!=data_q); rsp_data<=ram_out; -> RESP.
//   MY_RAM_8_CTRL_READBACK_EN undefined:
//     - No VERIFY state; WRITE goes straight to RESP.
//     - rsp_err is set only by reserved op.
// TESTING
//   1. reset; WRITE a=5 d=16'hBEEF; READ a=5
//      -> rsp_data=16'hBEEF, rsp_err=0; latency 2 each.
//   2. FILL d=16'h1234
//      -> ram_load=1 for 8 consecutive cycles, ram_addr 0..7; rsp_valid 9 edges after accept.
//      -> READ of every address returns 16'h1234.
//   3. READ with rsp_ready=0 for 3 cycles
//      -> rsp_valid, rsp_data stable; cmd_ready=0; ram_load=0; one response only.
//   4. cmd_op=2'b11, d=16'hFFFF
//      -> rsp_err=1, rsp_data=0; ram_load never asserted; RAM contents unchanged.
//   5. RAM pre-filled with 0; FILL 16'hA5A5; reset asserted on the 4th FILL cycle
//      -> words 0..2 = 16'hA5A5, words 3..7 = 0; ram_load=0 during reset; cmd_ready=1 after.
//   6. Macro on, RAM model forces bit0 stuck at 0; WRITE a=2 d=16'h0001
//      -> rsp_err=1, rsp_data=16'h0000; with a good RAM -> rsp_err=0.

Source files
------------

// File: rtl/my_ram_8_ctrl.sv
// ---------------------------------------------------------------------------
// my_ram_8_ctrl
//   Initiator-side controller for an 8-word x 16-bit RAM whose output is
//   combinational in its address and which captures its input on a rising
//   edge when load is high. The controller accepts READ / WRITE / FILL
//   commands on a valid/ready port and drives the RAM pins. It returns exactly
//   one response per command on a valid/ready response port. It is the sole
//   owner of the RAM load line.
//
//   Optional feature macro: MY_RAM_8_CTRL_READBACK_EN
//     When defined, every WRITE is followed by a one-cycle VERIFY read of the
//     same word. rsp_err flags a readback mismatch, and rsp_data carries the
//     word that was read back.
//
// Ports
//   clk        in   rising-edge clock (shared with the RAM)
//   reset      in   synchronous, active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  controller idle, command will be accepted
//   cmd_op     in   00 READ, 01 WRITE, 10 FILL, 11 reserved
//   cmd_addr   in   target word (ignored by FILL)
//   cmd_data   in   write / fill value
//   rsp_valid  out  response available
//   rsp_ready  in   response consumed
//   rsp_data   out  READ: word read; WRITE/FILL: value written; reserved: 0
//   rsp_err    out  reserved op (or readback mismatch with the macro)
//   ram_addr   out  RAM address
//   ram_in     out  RAM write data
//   ram_load   out  RAM write strobe, never high while reset is high
//   ram_out    in   RAM read data (combinational in ram_addr)
// ---------------------------------------------------------------------------
module my_ram_8_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WRITE  = 3'd2,
        S_FILL   = 3'd3,
`ifdef MY_RAM_8_CTRL_READBACK_EN
        S_VERIFY = 3'd4,
`endif
        S_RESP   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_cnt;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic                w_load;

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_READ:  w_next = S_READ;
                        OP_WRITE: w_next = S_WRITE;
                        OP_FILL:  w_next = S_FILL;
                        default:  w_next = S_RESP;  // reserved op answers at once
                    endcase
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_READ: w_next = S_RESP;
            S_WRITE: begin
`ifdef MY_RAM_8_CTRL_READBACK_EN
                w_next = S_VERIFY;
`else
                w_next = S_RESP;
`endif
            end
            S_FILL: begin
                // Leave after the last word so the counter never wraps into a write
                if (r_cnt == CNT_LAST) begin
                    w_next = S_RESP;
                end else begin
                    w_next = S_FILL;
                end
            end
`ifdef MY_RAM_8_CTRL_READBACK_EN
            S_VERIFY: w_next = S_RESP;
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_RESP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // RAM pin decode; address parks at 0 and load stays low outside access states
    always_comb begin
        w_ram_addr = {ADDR_W{1'b0}};
        w_load     = 1'b0;
        case (r_state)
            S_READ: begin
                w_ram_addr = r_addr;
            end
            S_WRITE: begin
                w_ram_addr = r_addr;
                w_load     = 1'b1;
            end
            S_FILL: begin
                w_ram_addr = r_cnt;
                w_load     = 1'b1;
            end
`ifdef MY_RAM_8_CTRL_READBACK_EN
            S_VERIFY: begin
                w_ram_addr = r_addr;
            end
`endif
            default: begin
                w_ram_addr = {ADDR_W{1'b0}};
                w_load     = 1'b0;
            end
        endcase
    end

    // State, command latch, fill counter and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= {ADDR_W{1'b0}};
            r_data     <= {DATA_W{1'b0}};
            r_cnt      <= {ADDR_W{1'b0}};
            r_rsp_data <= {DATA_W{1'b0}};
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr <= cmd_addr;
                        r_data <= cmd_data;
                        r_cnt  <= {ADDR_W{1'b0}};
                        if (cmd_op == 2'b11) begin
                            r_rsp_err  <= 1'b1;
                            r_rsp_data <= {DATA_W{1'b0}};
                        end
                    end
                end
                S_READ: begin
                    r_rsp_data <= ram_out;
                end
                S_WRITE: begin
                    r_rsp_data <= r_data;
                end
                S_FILL: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_rsp_data <= r_data;
                    end
                end
`ifdef MY_RAM_8_CTRL_READBACK_EN
                S_VERIFY: begin
                    r_rsp_err  <= (ram_out != r_data);
                    r_rsp_data <= ram_out;
                end
`endif
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_err <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_err <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign ram_addr  = w_ram_addr;
    assign ram_in    = r_data;
    // Gate with reset so no RAM write can land on a reset edge
    assign ram_load  = w_load & ~reset;

endmodule
